// File: rtl/word_tokenizer.sv
// word_tokenizer: splits a byte stream into whitespace-delimited words.
//
// Buffers up to WIDTH-1 non-delimiter bytes and presents them as a packed
// character array plus length, with valid/ready handshaking on both sides.
// Delimiters: 0x20, 0x09, 0x0A, 0x0D. Words that overflow are dropped (o_err
// pulses) and the remainder of that word is discarded.
//
// Optional feature macro: WORD_TOKENIZER_COMMENT_EN
//   defined   -> a '\' (0x5C) seen between words starts a comment that runs
//                to the next LF/CR.
//   undefined -> '\' is an ordinary word character.
//
// Ports:
//   i_clk    clock, rising edge
//   i_rst_n  asynchronous active-low reset
//   i_data   incoming character
//   i_valid  i_data is valid
//   o_ready  a character can be accepted this cycle (low while emitting)
//   o_word   WIDTH characters, character k at bits [k*8 +: 8]
//   o_len    number of valid characters in o_word
//   o_valid  o_word/o_len hold a complete word
//   i_ready  downstream accepts the word this cycle
//   o_err    one-cycle pulse on word overflow
module word_tokenizer #(
  parameter  int WIDTH      = 32,
  localparam int DATA_WIDTH = 8
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic [DATA_WIDTH-1:0]       i_data,
  input  logic                        i_valid,
  output logic                        o_ready,
  output logic [WIDTH*DATA_WIDTH-1:0] o_word,
  output logic [$clog2(WIDTH)-1:0]    o_len,
  output logic                        o_valid,
  input  logic                        i_ready,
  output logic                        o_err
);

  localparam int LEN_W = $clog2(WIDTH);
  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WORD,
    S_EMIT,
    S_DRAIN
`ifdef WORD_TOKENIZER_COMMENT_EN
    , S_COMMENT
`endif
  } state_t;

  state_t                               r_state;
  state_t                               w_state_nxt;
  logic [WIDTH-1:0][DATA_WIDTH-1:0]     r_word;
  logic [LEN_W-1:0]                     r_len;
  logic                                 r_err;

  logic w_accept;
  logic w_delim;
  logic w_store;     // write i_data at index r_len and bump the length
  logic w_overflow;  // word too long: drop buffer, flag error
  logic w_clear;     // word handed off downstream

  assign w_accept = i_valid && o_ready;
  assign w_delim  = (i_data == 8'h20) || (i_data == 8'h09) ||
                    (i_data == 8'h0A) || (i_data == 8'h0D);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_store     = 1'b0;
    w_overflow  = 1'b0;
    w_clear     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept && !w_delim) begin
`ifdef WORD_TOKENIZER_COMMENT_EN
          if (i_data == 8'h5C) begin
            w_state_nxt = S_COMMENT;
          end else begin
            w_store     = 1'b1;
            w_state_nxt = S_WORD;
          end
`else
          w_store     = 1'b1;
          w_state_nxt = S_WORD;
`endif
        end
      end
      S_WORD: begin
        if (w_accept) begin
          if (w_delim) begin
            w_state_nxt = S_EMIT;
          end else if (r_len == MAX_LEN) begin
            w_overflow  = 1'b1;
            w_state_nxt = S_DRAIN;
          end else begin
            w_store = 1'b1;
          end
        end
      end
      S_EMIT: begin
        if (i_ready) begin
          w_clear     = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      S_DRAIN: begin
        if (w_accept && w_delim) begin
          w_state_nxt = S_IDLE;
        end
      end
`ifdef WORD_TOKENIZER_COMMENT_EN
      S_COMMENT: begin
        if (w_accept && ((i_data == 8'h0A) || (i_data == 8'h0D))) begin
          w_state_nxt = S_IDLE;
        end
      end
`endif
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Buffer is cleared whenever a word leaves (emitted or dropped), so the
  // length is always 0 in IDLE and storing at r_len also covers the first char.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_word <= '0;
      r_len  <= '0;
      r_err  <= 1'b0;
    end else begin
      r_err <= w_overflow;
      if (w_clear || w_overflow) begin
        r_word <= '0;
        r_len  <= '0;
      end else if (w_store) begin
        r_word[r_len] <= i_data;
        r_len         <= r_len + LEN_W'(1);
      end
    end
  end

  assign o_ready = (r_state != S_EMIT);
  assign o_valid = (r_state == S_EMIT);
  assign o_word  = r_word;
  assign o_len   = r_len;
  assign o_err   = r_err;

endmodule

// File: tb/tb_word_tokenizer.sv
// Testbench for word_tokenizer: behavioural word-collector model compared
// against the DUT every cycle, plus literal expectations on emitted words.
module tb_word_tokenizer;

  localparam int W  = 8;
  localparam int LW = $clog2(W);
`ifdef WORD_TOKENIZER_COMMENT_EN
  localparam bit COMMENT_EN = 1'b1;
`else
  localparam bit COMMENT_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic [7:0]    i_data;
  logic          i_valid;
  logic          i_ready;
  logic          o_ready;
  logic [W*8-1:0] o_word;
  logic [LW-1:0] o_len;
  logic          o_valid;
  logic          o_err;

  word_tokenizer #(.WIDTH(W)) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .i_data (i_data),
    .i_valid(i_valid),
    .o_ready(o_ready),
    .o_word (o_word),
    .o_len  (o_len),
    .o_valid(o_valid),
    .i_ready(i_ready),
    .o_err  (o_err)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Model: characters of the word being collected, what to do with the next
  // byte (0 between words, 1 collecting, 2 skipping an overlong word,
  // 3 inside a comment), and whether a finished word awaits handoff.
  byte unsigned cur[$];
  int           m_mode = 0;
  bit           m_emit = 1'b0;
  bit           m_err  = 1'b0;
  string        m_log[$];
  int           m_err_cnt   = 0;
  int           dut_err_cnt = 0;

  function automatic bit is_delim(byte unsigned c);
    return (c == 8'h20) || (c == 8'h09) || (c == 8'h0A) || (c == 8'h0D);
  endfunction

  function automatic string word_str();
    string s = "";
    foreach (cur[i]) s = $sformatf("%s%c", s, cur[i]);
    return s;
  endfunction

  task automatic check(string name, logic [255:0] act, logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic check_str(string name, string act, string exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=\"%s\" required=\"%s\"", name, act, exp);
    end
  endtask

  task automatic model_step();
    byte unsigned c;
    m_err = 1'b0;
    if (m_emit) begin
      if (i_ready) begin
        m_log.push_back(word_str());
        cur.delete();
        m_emit = 1'b0;
        m_mode = 0;
      end
    end else if (i_valid) begin
      c = i_data;
      case (m_mode)
        0: if (!is_delim(c)) begin
             if (COMMENT_EN && c == 8'h5C) m_mode = 3;
             else begin cur.push_back(c); m_mode = 1; end
           end
        1: if (is_delim(c)) m_emit = 1'b1;
           else if (cur.size() < W - 1) cur.push_back(c);
           else begin m_err = 1'b1; m_err_cnt++; cur.delete(); m_mode = 2; end
        2: if (is_delim(c)) m_mode = 0;
        default: if (c == 8'h0A || c == 8'h0D) m_mode = 0;
      endcase
    end
  endtask

  always @(negedge clk) begin : compare
    logic [W*8-1:0] ew;
    if (!rst_n) begin
      cur.delete();
      m_mode = 0;
      m_emit = 1'b0;
      m_err  = 1'b0;
    end
    ew = '0;
    foreach (cur[i]) ew[i*8 +: 8] = cur[i];
    check("cyc_valid", o_valid, m_emit);
    check("cyc_ready", o_ready, !m_emit);
    check("cyc_len",   o_len, cur.size());
    check("cyc_word",  o_word, ew);
    check("cyc_err",   o_err, m_err);
    if (o_err) dut_err_cnt++;
    if (rst_n) model_step();
  end

  task automatic send(byte unsigned c);
    bit ok;
    int n = 0;
    i_data  = c;
    i_valid = 1'b1;
    forever begin
      @(negedge clk);
      ok = o_ready;
      @(posedge clk);
      #1;
      if (ok) break;
      n++;
      if (n > 50) begin
        check("send_timeout", 1, 0);
        break;
      end
    end
    i_valid = 1'b0;
  endtask

  task automatic send_str(string s);
    for (int i = 0; i < s.len(); i++) send(s[i]);
  endtask

  task automatic idle(int n);
    i_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expect_words(string name, int n, string w0 = "", string w1 = "",
                              string w2 = "", string w3 = "");
    string ws[4];
    ws[0] = w0; ws[1] = w1; ws[2] = w2; ws[3] = w3;
    check({name, "_count"}, m_log.size(), n);
    for (int i = 0; i < n && i < m_log.size(); i++)
      check_str($sformatf("%s_w%0d", name, i), m_log[i], ws[i]);
  endtask

  byte unsigned tbl[10] = '{8'h41, 8'h42, 8'h20, 8'h0A, 8'h5C,
                            8'h43, 8'h09, 8'h0D, 8'h44, 8'h45};

  initial begin
    rst_n   = 1'b0;
    i_valid = 1'b0;
    i_data  = 8'h00;
    i_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", o_ready, 1);
    check("rst_valid", o_valid, 0);
    check("rst_len",   o_len, 0);
    check("rst_word",  o_word, 0);
    check("rst_err",   o_err, 0);
    rst_n = 1'b1;

    // Basic split
    m_log.delete();
    send_str("0x1F ");
    @(negedge clk);
    check("basic_len",  o_len, 4);
    check("basic_word", o_word[39:0], 40'h0046317830);
    @(posedge clk); #1;
    send_str("42\n");
    idle(4);
    expect_words("basic", 2, "0x1F", "42");

    // Backpressure
    m_log.delete();
    i_ready = 1'b0;
    send_str("DUP ");
    i_data  = "X";
    i_valid = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("bp_valid", o_valid, 1);
      check("bp_ready", o_ready, 0);
      check("bp_len",   o_len, 3);
      check("bp_word",  o_word[31:0], 32'h00505544);
      @(posedge clk); #1;
    end
    i_ready = 1'b1;
    send("X");
    send(" ");
    idle(4);
    expect_words("bp", 2, "DUP", "X");

    // Leading and repeated delimiters
    m_log.delete();
    send_str("  \t\r\nAB  ");
    idle(4);
    expect_words("lead", 1, "AB");

    // Overflow
    m_log.delete();
    m_err_cnt   = 0;
    dut_err_cnt = 0;
    send_str("ABCDEFGHIJ K ");
    idle(4);
    expect_words("ovf", 1, "K");
    check("ovf_model_errs", m_err_cnt, 1);
    check("ovf_dut_errs",   dut_err_cnt, 1);

    // Reset mid-word
    send_str("ABC");
    rst_n = 1'b0;
    #1;
    check("mid_rst_len",   o_len, 0);
    check("mid_rst_word",  o_word, 0);
    check("mid_rst_valid", o_valid, 0);
    check("mid_rst_ready", o_ready, 1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    m_log.delete();
    send_str("Z ");
    @(negedge clk);
    check("z_len",  o_len, 1);
    check("z_word", o_word, 64'h5A);
    @(posedge clk); #1;
    idle(4);
    expect_words("z", 1, "Z");

    // Comment handling
    m_log.delete();
    send_str("\\ 0x10 junk\n7 ");
    idle(4);
    if (COMMENT_EN) expect_words("cmt", 1, "7");
    else            expect_words("cmt", 4, "\\", "0x10", "junk", "7");

    // Random traffic against the model
    for (int cyc = 0; cyc < 3000; cyc++) begin
      i_valid = ($urandom_range(0, 3) != 0);
      i_data  = (cyc % 400 < 200) ? tbl[$urandom_range(0, 9)]
                                  : tbl[$urandom_range(0, 1)];
      i_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
    end
    i_valid = 1'b0;
    i_ready = 1'b1;
    idle(4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
